// File: rtl/flash_prog_seq.sv
// flash_prog_seq: runs JEDEC-style command cycles on the cartridge flash.
// A host command is captured once. The sequencer then owns the flash bus
// (bus_own) and drives unlock/command/data write cycles, then waits for the
// operation to complete.
// Build option FLASH_TOGGLE_POLL_EN: when defined, completion is detected by
// DQ6 toggle polling with DQ5 timeout detection. When undefined, a fixed
// WAIT_CYC-clock wait is used and error is tied low.
module flash_prog_seq #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned WAIT_CYC   = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_data,
    output logic                  bus_own,
    output logic [ADDR_WIDTH-1:0] flash_addr,
    output logic [7:0]            flash_dout,
    input  logic [7:0]            flash_din,
    output logic                  flash_ce,
    output logic                  we,
    output logic                  oe,
    output logic                  done,
    output logic                  error
);

    localparam logic [1:0] OP_PROG = 2'b00;
    localparam logic [1:0] OP_SECT = 2'b01;
    localparam logic [1:0] OP_RST  = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] UNLOCK_1 = ADDR_WIDTH'(11'h555);
    localparam logic [ADDR_WIDTH-1:0] UNLOCK_2 = ADDR_WIDTH'(10'h2AA);

    localparam int unsigned TMAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] SETUP_INIT = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_INIT = TW'(PULSE_CYC - 1);

    typedef enum logic [3:0] {
        StIdle, StSetup, StPulse, StHold, StWait, StRead, StGap, StDone, StError
    } state_t;

    state_t                  state_q;
    logic [1:0]              op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              data_q;
    logic [2:0]              idx_q;
    logic [TW-1:0]           tmr_q;
    // Set while the post-error reset cycle runs; its HOLD returns straight to idle.
    logic                    recov_q;

    // {address, data} of write cycle idx for the given operation.
    function automatic logic [ADDR_WIDTH+7:0] cycle_word(
        input logic [1:0]            op,
        input logic [2:0]            idx,
        input logic [ADDR_WIDTH-1:0] tgt,
        input logic [7:0]            pdata
    );
        logic [ADDR_WIDTH-1:0] a;
        logic [7:0]            d;
        a = UNLOCK_1;
        d = 8'hAA;
        if (op == OP_RST) begin
            a = '0;
            d = 8'hF0;
        end else if (op == OP_PROG) begin
            case (idx)
                3'd0:    begin a = UNLOCK_1; d = 8'hAA; end
                3'd1:    begin a = UNLOCK_2; d = 8'h55; end
                3'd2:    begin a = UNLOCK_1; d = 8'hA0; end
                default: begin a = tgt;      d = pdata; end
            endcase
        end else begin
            case (idx)
                3'd0:    begin a = UNLOCK_1; d = 8'hAA; end
                3'd1:    begin a = UNLOCK_2; d = 8'h55; end
                3'd2:    begin a = UNLOCK_1; d = 8'h80; end
                3'd3:    begin a = UNLOCK_1; d = 8'hAA; end
                3'd4:    begin a = UNLOCK_2; d = 8'h55; end
                default: begin
                    if (op == OP_SECT) begin
                        a = tgt;
                        d = 8'h30;
                    end else begin
                        a = UNLOCK_1;
                        d = 8'h10;
                    end
                end
            endcase
        end
        return {a, d};
    endfunction

    function automatic logic is_last(input logic [1:0] op, input logic [2:0] idx);
        if (op == OP_RST) return 1'b1;
        if (op == OP_PROG) return idx >= 3'd3;
        return idx >= 3'd5;
    endfunction

    logic [ADDR_WIDTH+7:0] acc_word;
    logic [ADDR_WIDTH+7:0] nxt_word;
    logic                  cur_last;

    assign acc_word  = cycle_word(cmd_op, 3'd0, cmd_addr, cmd_data);
    assign nxt_word  = cycle_word(op_q, idx_q + 3'd1, addr_q, data_q);
    assign cur_last  = is_last(op_q, idx_q);
    assign cmd_ready = (state_q == StIdle);

`ifdef FLASH_TOGGLE_POLL_EN
    logic [1:0] rd_idx_q;     // 0..3 = RD_A, RD_B, RD_C, RD_D
    logic       phase_q;      // second clock of a read takes the sample
    logic       dq6_first_q;  // DQ6 of RD_A / RD_C
    logic       dq6_second_q; // DQ6 of RD_B / RD_D
    logic       dq5_second_q; // DQ5 of RD_B
    logic       error_q;
    logic       unused_din;

    assign error      = error_q;
    assign unused_din = ^{flash_din[7], flash_din[4:0]};
`else
    localparam int unsigned WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WW-1:0] WAIT_INIT = WW'(WAIT_CYC - 1);

    logic [WW-1:0] wait_q;
    logic          unused_din;

    assign error      = 1'b0;
    assign unused_din = ^flash_din;
`endif

    // Sequencer FSM with all flash-side outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            idx_q      <= '0;
            tmr_q      <= '0;
            recov_q    <= 1'b0;
            bus_own    <= 1'b0;
            flash_addr <= '0;
            flash_dout <= '0;
            flash_ce   <= 1'b1;
            we         <= 1'b1;
            oe         <= 1'b1;
            done       <= 1'b0;
`ifdef FLASH_TOGGLE_POLL_EN
            rd_idx_q     <= '0;
            phase_q      <= 1'b0;
            dq6_first_q  <= 1'b0;
            dq6_second_q <= 1'b0;
            dq5_second_q <= 1'b0;
            error_q      <= 1'b0;
`else
            wait_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q                     <= cmd_op;
                        addr_q                   <= cmd_addr;
                        data_q                   <= cmd_data;
                        idx_q                    <= '0;
                        recov_q                  <= 1'b0;
                        bus_own                  <= 1'b1;
                        {flash_addr, flash_dout} <= acc_word;
                        flash_ce                 <= 1'b0;
                        tmr_q                    <= SETUP_INIT;
                        state_q                  <= StSetup;
`ifdef FLASH_TOGGLE_POLL_EN
                        error_q                  <= 1'b0;
`endif
                    end
                end
                StSetup: begin
                    if (tmr_q == '0) begin
                        we      <= 1'b0;
                        tmr_q   <= PULSE_INIT;
                        state_q <= StPulse;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                StPulse: begin
                    if (tmr_q == '0) begin
                        we       <= 1'b1;
                        flash_ce <= 1'b1;
                        state_q  <= StHold;
                    end else begin
                        tmr_q <= tmr_q - TW'(1);
                    end
                end
                StHold: begin
                    if (!cur_last) begin
                        idx_q                    <= idx_q + 3'd1;
                        {flash_addr, flash_dout} <= nxt_word;
                        flash_ce                 <= 1'b0;
                        tmr_q                    <= SETUP_INIT;
                        state_q                  <= StSetup;
                    end else if (recov_q) begin
                        recov_q <= 1'b0;
                        bus_own <= 1'b0;
                        state_q <= StIdle;
                    end else if (op_q == OP_RST) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
`ifdef FLASH_TOGGLE_POLL_EN
                        flash_ce <= 1'b0;
                        oe       <= 1'b0;
                        phase_q  <= 1'b0;
                        rd_idx_q <= '0;
                        state_q  <= StRead;
`else
                        wait_q   <= WAIT_INIT;
                        state_q  <= StWait;
`endif
                    end
                end
`ifdef FLASH_TOGGLE_POLL_EN
                StRead: begin
                    if (!phase_q) begin
                        phase_q <= 1'b1;
                    end else begin
                        if (rd_idx_q[0]) begin
                            dq6_second_q <= flash_din[6];
                            dq5_second_q <= flash_din[5];
                        end else begin
                            dq6_first_q <= flash_din[6];
                        end
                        flash_ce <= 1'b1;
                        oe       <= 1'b1;
                        state_q  <= StGap;
                    end
                end
                // Idle clock between reads; the pair decision is made here.
                StGap: begin
                    if (rd_idx_q[0] && (dq6_second_q == dq6_first_q)) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else if (rd_idx_q == 2'd3) begin
                        error_q <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StError;
                    end else begin
                        flash_ce <= 1'b0;
                        oe       <= 1'b0;
                        phase_q  <= 1'b0;
                        state_q  <= StRead;
                        if (rd_idx_q == 2'd1) begin
                            rd_idx_q <= dq5_second_q ? 2'd2 : 2'd0;
                        end else begin
                            rd_idx_q <= rd_idx_q + 2'd1;
                        end
                    end
                end
                // Report the failure, then issue a reset cycle before going idle.
                StError: begin
                    done       <= 1'b0;
                    op_q       <= OP_RST;
                    idx_q      <= '0;
                    recov_q    <= 1'b1;
                    flash_addr <= '0;
                    flash_dout <= 8'hF0;
                    flash_ce   <= 1'b0;
                    tmr_q      <= SETUP_INIT;
                    state_q    <= StSetup;
                end
`else
                StWait: begin
                    if (wait_q == '0) begin
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
`endif
                StDone: begin
                    done    <= 1'b0;
                    bus_own <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_prog_seq.sv
// Scoreboard bench for flash_prog_seq: the driver pushes expected write
// cycles and completions, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_flash_prog_seq;

    localparam int unsigned AW    = 19;
    localparam int unsigned SETUP = 1;
    localparam int unsigned PULSE = 2;
    localparam int unsigned WAITC = 8;

    logic          clock     = 1'b0;
    logic          reset     = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op    = 2'b00;
    logic [AW-1:0] cmd_addr  = '0;
    logic [7:0]    cmd_data  = 8'h00;
    logic          cmd_ready, bus_own, flash_ce, we, oe, done, error;
    logic [AW-1:0] flash_addr;
    logic [7:0]    flash_dout, flash_din;

    flash_prog_seq #(
        .ADDR_WIDTH(AW), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .WAIT_CYC(WAITC)
    ) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .bus_own(bus_own),
        .flash_addr(flash_addr), .flash_dout(flash_dout), .flash_din(flash_din),
        .flash_ce(flash_ce), .we(we), .oe(oe), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } cyc_t;
    typedef struct { logic err; int lat; logic rel; } fin_t;
    cyc_t exp_cyc[$];
    fin_t exp_fin[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash model: DQ6 toggles on each completed read for the first tog_n reads,
    // then holds its last value; DQ5 is a constant chosen per command.
    int   tog_n   = 0;
    logic dq5_set = 1'b0;
    int   rd_cnt  = 0;
    logic prev_oe = 1'b1;

    function automatic logic dq6_at(input int r, input int t);
        int tm;
        if (r < t) return r[0];
        if (t == 0) return 1'b0;
        tm = t - 1;
        return tm[0];
    endfunction

    assign flash_din = {1'b0, dq6_at(rd_cnt, tog_n), dq5_set, 5'b00000};

    always @(negedge clock) begin
        if (!bus_own) rd_cnt = 0;
        else if (oe && !prev_oe) rd_cnt++;
        prev_oe = oe;
    end

    // Number of reads the toggle-bit rules need, and whether they end in error.
    function automatic int poll_reads(input int t, input logic d5, output logic err);
        int   r;
        logic a, b;
        r   = 0;
        err = 1'b0;
        for (int k = 0; k < 64; k++) begin
            a = dq6_at(r, t);
            b = dq6_at(r + 1, t);
            r += 2;
            if (a == b) return r;
            if (d5) begin
                a = dq6_at(r, t);
                b = dq6_at(r + 1, t);
                r += 2;
                err = (a != b);
                return r;
            end
        end
        return r;
    endfunction

    // Monitor: compares write cycles and completions against the queues.
    int   pulse_len  = 0;
    int   since_hold = 1000;
    logic prev_we    = 1'b1;
    logic prev_done  = 1'b0;
    logic chk_rel    = 1'b0;
    logic rel_exp    = 1'b0;

    always @(negedge clock) begin
        cyc_t c;
        fin_t f;
        if (reset) begin
            pulse_len  = 0;
            since_hold = 1000;
            prev_we    = 1'b1;
            prev_done  = 1'b0;
            chk_rel    = 1'b0;
        end else begin
            since_hold++;
            if (chk_rel) begin
                check("bus_release", bus_own, rel_exp ? 1'b0 : 1'b1);
                chk_rel = 1'b0;
            end
            check("ce_we_oe_overlap", !flash_ce && !we && !oe, 1'b0);
            check("we_without_bus", !we && !bus_own, 1'b0);
`ifndef FLASH_TOGGLE_POLL_EN
            check("oe_idle", oe, 1'b1);
`endif
            if (!we && prev_we) begin
                if (exp_cyc.size() == 0) begin
                    check("unexpected_write", 1'b1, 1'b0);
                end else begin
                    c = exp_cyc.pop_front();
                    check("cycle_addr", flash_addr, c.addr);
                    check("cycle_data", flash_dout, c.data);
                    check("cycle_ce", flash_ce, 1'b0);
                end
                pulse_len = 1;
            end else if (!we) begin
                pulse_len++;
            end
            if (we && !prev_we) begin
                check("pulse_len", pulse_len, PULSE);
                since_hold = 0;
            end
            if (done) begin
                check("done_width", prev_done, 1'b0);
                if (exp_fin.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    f = exp_fin.pop_front();
                    check("done_error", error, f.err);
                    check("done_latency", since_hold, f.lat);
                    chk_rel = 1'b1;
                    rel_exp = f.rel;
                end
            end
            prev_we   = we;
            prev_done = done;
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (cmd_ready && !bus_own) return;
        end
        check("idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic push_cyc(input logic [AW-1:0] a, input logic [7:0] d);
        cyc_t c;
        c.addr = a;
        c.data = d;
        exp_cyc.push_back(c);
    endtask

    // Push the expected behaviour of one command, then present it for one clock.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [7:0] d,
                         input int t, input logic d5);
        fin_t          f;
        logic [AW-1:0] u1, u2;
        int            n;
        logic          e;
        u1 = AW'(11'h555);
        u2 = AW'(10'h2AA);
        wait_idle();
        if (op == 2'b11) begin
            push_cyc('0, 8'hF0);
        end else begin
            push_cyc(u1, 8'hAA);
            push_cyc(u2, 8'h55);
            if (op == 2'b00) begin
                push_cyc(u1, 8'hA0);
                push_cyc(a, d);
            end else begin
                push_cyc(u1, 8'h80);
                push_cyc(u1, 8'hAA);
                push_cyc(u2, 8'h55);
                if (op == 2'b01) push_cyc(a, 8'h30);
                else push_cyc(u1, 8'h10);
            end
        end
        if (op == 2'b11) begin
            f.err = 1'b0; f.lat = 1; f.rel = 1'b1;
        end else begin
`ifdef FLASH_TOGGLE_POLL_EN
            n = poll_reads(t, d5, e);
            f.err = e; f.lat = 3 * n + 1; f.rel = !e;
            if (e) push_cyc('0, 8'hF0);
`else
            n = 0; e = 1'b0;
            f.err = 1'b0; f.lat = int'(WAITC) + 1; f.rel = 1'b1;
`endif
        end
        exp_fin.push_back(f);
        tog_n     = t;
        dq5_set   = d5;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        check("accept_bus_own", bus_own, 1'b1);
        check("accept_ready", cmd_ready, 1'b0);
        check("accept_error_clear", error, 1'b0);
    endtask

    initial begin
        int   nf;
        logic pw;
        #1 reset = 1'b1;
        #2;
        check("rst_bus_own", bus_own, 1'b0);
        check("rst_ce", flash_ce, 1'b1);
        check("rst_we", we, 1'b1);
        check("rst_oe", oe, 1'b1);
        check("rst_addr", flash_addr, '0);
        check("rst_dout", flash_dout, 8'h00);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Program with DQ6 toggling for three reads.
        issue(2'b00, AW'(20'h12345), 8'h5A, 3, 1'b0);

        // Sector erase with a second request arriving while busy.
        issue(2'b01, AW'(20'h40000), 8'h00, 2, 1'b0);
        repeat (3) @(negedge clock);
        cmd_op    = 2'b11;
        cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("busy_not_ready", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;

        // Reset command: single cycle, no polling.
        issue(2'b11, AW'(20'h7FFFF), 8'h33, 0, 1'b0);

`ifdef FLASH_TOGGLE_POLL_EN
        // Endless toggling with DQ5 set: error, then recovery reset cycle.
        issue(2'b00, AW'(20'h00100), 8'hC3, 100000, 1'b1);
        wait_idle();
        check("error_sticky", error, 1'b1);
`endif
        issue(2'b10, AW'(20'h11111), 8'h00, 1, 1'b0);

        // Asynchronous reset during the second write pulse of a program.
        issue(2'b00, AW'(20'h2468A), 8'h96, 0, 1'b0);
        nf = 0;
        pw = 1'b1;
        for (int k = 0; k < 100 && nf < 2; k++) begin
            @(negedge clock);
            if (!we && pw) nf++;
            pw = we;
        end
        check("second_pulse_seen", nf, 2);
        #2;
        reset = 1'b1;
        exp_cyc.delete();
        exp_fin.delete();
        #1;
        check("midrst_we", we, 1'b1);
        check("midrst_ce", flash_ce, 1'b1);
        check("midrst_oe", oe, 1'b1);
        check("midrst_bus_own", bus_own, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_ready", cmd_ready, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        issue(2'b00, AW'(20'h0ABCD), 8'hE1, 2, 1'b0);

        // Randomised commands.
        for (int i = 0; i < 10; i++) begin
            issue(2'($urandom_range(0, 3)), AW'($urandom), 8'($urandom),
                  int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

        wait_idle();
        repeat (3) @(negedge clock);
        check("cycles_left", exp_cyc.size(), 0);
        check("dones_left", exp_fin.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
